// File: rtl/phy_reg_free_list_pkg.sv
// Shared rename types and pointer helpers.
// Fixed-size IDs plus parametric-friendly constants.
package phy_reg_free_list_pkg;

  localparam int NUM_PHY_REGS_C = 128;
  localparam int ARCH_REGS_C    = 32;
  localparam int PHY_W_C        = $clog2(NUM_PHY_REGS_C);
  localparam int ARCH_W_C       = $clog2(ARCH_REGS_C);

  typedef logic [PHY_W_C-1:0]  PhyIdx_T;
  typedef logic [ARCH_W_C-1:0] ArchRegId_T;

  typedef struct packed {
    logic    valid;
    PhyIdx_T idx;
  } PhyRegisterId_T;

  // Ring pointer advance; needs ptr < depth and k <= depth,
  // so a single conditional subtract covers the wrap.
  function automatic int unsigned ptr_add(
    input int unsigned ptr,
    input int unsigned k,
    input int unsigned depth
  );
    int unsigned s;
    s = ptr + k;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/phy_reg_free_list_compactor.sv
// Packs sparse free lanes lowest-lane-first.
// Also reports how many lanes were valid.
module free_lane_compactor
  import phy_reg_free_list_pkg::*;
#(
  parameter int FW = 2,
  parameter int PW = 7,
  localparam int CNTW = $clog2(FW+1)
) (
  input  logic [FW-1:0]         valid,
  input  logic [FW-1:0][PW-1:0] id,
  output logic [FW-1:0][PW-1:0] pk_id,
  output logic [CNTW-1:0]       cnt
);

  logic [CNTW-1:0] n;

  // Each valid lane lands in the slot equal to the valid lanes before it
  always_comb begin
    pk_id = '0;
    n     = '0;
    for (int i = 0; i < FW; i++) begin
      if (valid[i]) begin
        for (int s = 0; s < FW; s++) begin
          if (n == CNTW'(s)) pk_id[s] = id[i];
        end
        n = n + CNTW'(1);
      end
    end
    cnt = n;
  end

endmodule

// File: rtl/phy_reg_free_list.sv
// Circular free list of physical register IDs.
// Speculative head for rename, retired head for flush.
module phy_reg_free_list
  import phy_reg_free_list_pkg::*;
#(
  parameter int NUM_PHY_REGS = NUM_PHY_REGS_C,
  parameter int ARCH_REGS    = ARCH_REGS_C,
  parameter int ALLOC_WIDTH  = 2,
  parameter int FREE_WIDTH   = 2,
  localparam int PW    = $clog2(NUM_PHY_REGS),
  localparam int DEPTH = NUM_PHY_REGS - ARCH_REGS,
  localparam int CW    = $clog2(DEPTH+1),
  localparam int AW    = ALLOC_WIDTH,
  localparam int FW    = FREE_WIDTH,
  localparam int RW    = $clog2(AW+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RW-1:0]         alloc_req_cnt,
  output logic                  alloc_ok,
  output logic [AW-1:0][PW-1:0] alloc_id,
  input  logic [FW-1:0]         free_valid,
  input  logic [FW-1:0][PW-1:0] free_id,
  input  logic [RW-1:0]         retire_cnt,
  input  logic                  recover,
  output logic [CW-1:0]         free_count,
  output logic                  err
);

  localparam int PTW  = $clog2(DEPTH);
  localparam int XW   = CW + 1;
  localparam int FCW  = $clog2(FW+1);

  logic [PW-1:0]  arr [DEPTH];
  logic [PTW-1:0] spec_head;
  logic [PTW-1:0] ret_head;
  logic [PTW-1:0] tail;
  logic [CW-1:0]  spec_cnt;
  logic [CW-1:0]  ret_cnt;
  logic           err_q;

  logic [FW-1:0][PW-1:0] pk_id;
  logic [FCW-1:0]        pk_cnt;

  logic [XW-1:0] req_x;
  logic [XW-1:0] ret_x;
  logic [XW-1:0] pop_x;
  logic [XW-1:0] avail;
  logic [XW-1:0] ret_eff;
  logic [XW-1:0] room;
  logic [XW-1:0] acc;
  logic [XW-1:0] ret_cnt_n;
  logic [XW-1:0] spec_cnt_n;
  logic          ret_over;
  logic          free_over;

  logic [PTW-1:0] spec_head_n;
  logic [PTW-1:0] ret_head_n;
  logic [PTW-1:0] tail_n;

  logic [AW-1:0][PTW-1:0] rd_ptr;
  logic [FW-1:0][PTW-1:0] wr_ptr;

  function automatic logic [PTW-1:0] adv(
    input logic [PTW-1:0] p,
    input logic [XW-1:0]  k
  );
    return PTW'(ptr_add(32'(p), 32'(k), DEPTH));
  endfunction

  free_lane_compactor #(
    .FW (FW),
    .PW (PW)
  ) u_compact (
    .valid (free_valid),
    .id    (free_id),
    .pk_id (pk_id),
    .cnt   (pk_cnt)
  );

  // Zero-latency read of the next IDs and the all-or-nothing grant
  always_comb begin
    req_x = XW'(alloc_req_cnt);
    for (int i = 0; i < AW; i++) begin
      rd_ptr[i]   = adv(spec_head, XW'(i));
      alloc_id[i] = arr[rd_ptr[i]];
    end
    alloc_ok = !rst && !recover
            && (req_x != '0)
            && (XW'(spec_cnt) >= req_x);
  end

  // Next pointers and counts from old state plus this cycle's deltas
  always_comb begin
    ret_x = XW'(retire_cnt);
    pop_x = XW'(pk_cnt);

    // Retire can only cover allocated, not-yet-retired entries
    avail    = XW'(ret_cnt) - XW'(spec_cnt);
    ret_over = ret_x > avail;
    ret_eff  = ret_over ? avail : ret_x;

    // Slots released by retire are reusable by the same cycle's frees
    room      = XW'(DEPTH) - XW'(ret_cnt) + ret_eff;
    free_over = pop_x > room;
    acc       = free_over ? room : pop_x;

    ret_cnt_n  = XW'(ret_cnt) - ret_eff + acc;
    ret_head_n = adv(ret_head, ret_eff);
    tail_n     = adv(tail, acc);

    if (recover) begin
      spec_head_n = ret_head_n;
      spec_cnt_n  = ret_cnt_n;
    end else if (alloc_ok) begin
      spec_head_n = adv(spec_head, req_x);
      spec_cnt_n  = XW'(spec_cnt) - req_x + acc;
    end else begin
      spec_head_n = spec_head;
      spec_cnt_n  = XW'(spec_cnt) + acc;
    end

    for (int j = 0; j < FW; j++) begin
      wr_ptr[j] = adv(tail, XW'(j));
    end
  end

  // State update; reset reloads the list with the unmapped PRs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        arr[k] <= PW'(ARCH_REGS + k);
      end
      spec_head <= '0;
      ret_head  <= '0;
      tail      <= '0;
      spec_cnt  <= CW'(DEPTH);
      ret_cnt   <= CW'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      for (int j = 0; j < FW; j++) begin
        if (XW'(j) < acc) arr[wr_ptr[j]] <= pk_id[j];
      end
      spec_head <= spec_head_n;
      ret_head  <= ret_head_n;
      tail      <= tail_n;
      spec_cnt  <= CW'(spec_cnt_n);
      ret_cnt   <= CW'(ret_cnt_n);
      err_q     <= err_q | ret_over | free_over;
    end
  end

  assign free_count = spec_cnt;
  assign err        = err_q;

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Randomized bench for phy_reg_free_list.
// Reference model keeps free and in-flight IDs as queues.
module tb_phy_reg_free_list;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      alloc_req_cnt;
  logic            alloc_ok;
  logic [1:0][6:0] alloc_id;
  logic [1:0]      free_valid;
  logic [1:0][6:0] free_id;
  logic [1:0]      retire_cnt;
  logic            recover;
  logic [6:0]      free_count;
  logic            err;

  int checks = 0;
  int errors = 0;

  int spec_q[$];
  int infl_q[$];
  bit m_err;

  int obs_ok;
  int obs_id0;
  int obs_id1;

  phy_reg_free_list dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req_cnt (alloc_req_cnt),
    .alloc_ok      (alloc_ok),
    .alloc_id      (alloc_id),
    .free_valid    (free_valid),
    .free_id       (free_id),
    .retire_cnt    (retire_cnt),
    .recover       (recover),
    .free_count    (free_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    spec_q = {};
    infl_q = {};
    for (int k = 0; k < 96; k++) spec_q.push_back(32 + k);
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_req_cnt = '0;
    free_valid = '0;
    free_id = '0;
    retire_cnt = '0;
    recover = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_free_count", int'(free_count), 96);
    chk("rst_err", int'(err), 0);
  endtask

  task automatic step(input int req, input int fv, input int f0,
                      input int f1, input int ret, input bit rec);
    bit ok;
    int eff;
    int room;
    int fr[$];
    @(negedge clk);
    alloc_req_cnt = 2'(req);
    free_valid = 2'(fv);
    free_id[0] = 7'(f0);
    free_id[1] = 7'(f1);
    retire_cnt = 2'(ret);
    recover = rec;
    #1;
    ok = !rec && req != 0 && spec_q.size() >= req;
    obs_ok = int'(alloc_ok);
    obs_id0 = int'(alloc_id[0]);
    obs_id1 = int'(alloc_id[1]);
    chk("alloc_ok", int'(alloc_ok), int'(ok));
    if (ok) begin
      for (int i = 0; i < req; i++) chk("alloc_id", int'(alloc_id[i]), spec_q[i]);
    end
    chk("free_count", int'(free_count), spec_q.size());
    chk("err", int'(err), int'(m_err));
    @(posedge clk);
    eff = ret;
    if (eff > infl_q.size()) begin
      m_err = 1'b1;
      eff = infl_q.size();
    end
    repeat (eff) void'(infl_q.pop_front());
    fr = {};
    if (fv[0]) fr.push_back(f0);
    if (fv[1]) fr.push_back(f1);
    room = 96 - (spec_q.size() + infl_q.size());
    while (fr.size() > room) begin
      m_err = 1'b1;
      void'(fr.pop_back());
    end
    if (ok) repeat (req) infl_q.push_back(spec_q.pop_front());
    foreach (fr[k]) spec_q.push_back(fr[k]);
    if (rec) begin
      spec_q = {infl_q, spec_q};
      infl_q = {};
    end
    #1;
  endtask

  initial begin
    int req, fv, ret, allowed, tot;
    bit rec;
    rst = 1'b1;
    alloc_req_cnt = '0;
    free_valid = '0;
    free_id = '0;
    retire_cnt = '0;
    recover = 1'b0;

    // first grant after reset
    do_reset();
    step(2, 0, 0, 0, 0, 0);
    chk("first_ok", obs_ok, 1);
    chk("first_id0", obs_id0, 32);
    chk("first_id1", obs_id1, 33);
    chk("first_fc", int'(free_count), 94);

    // drain, then a refused request
    repeat (47) step(2, 0, 0, 0, 0, 0);
    chk("drained_fc", int'(free_count), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("empty_ok", obs_ok, 0);
    chk("empty_fc", int'(free_count), 0);

    // no same-cycle bypass of a freed ID
    step(0, 0, 0, 0, 2, 0);
    step(1, 2, 0, 40, 0, 0);
    chk("bypass_ok", obs_ok, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("next_ok", obs_ok, 1);
    chk("next_id", obs_id0, 40);

    // recover to retired head
    do_reset();
    step(2, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("rec_ok", obs_ok, 0);
    chk("rec_fc", int'(free_count), 94);
    step(1, 0, 0, 0, 0, 0);
    chk("rec_id", obs_id0, 34);

    // wrap from index 95 to 0
    do_reset();
    repeat (47) step(2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (47) step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 3, 50, 51, 0, 0);
    step(0, 1, 52, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    chk("wrap_id0", obs_id0, 127);
    chk("wrap_id1", obs_id1, 50);
    step(2, 0, 0, 0, 0, 0);
    chk("wrap_id2", obs_id0, 51);
    chk("wrap_id3", obs_id1, 52);

    // overflow is sticky until reset
    do_reset();
    step(0, 1, 10, 0, 0, 0);
    chk("ovf_err", int'(err), 1);
    chk("ovf_fc", int'(free_count), 96);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    chk("ovf_sticky", int'(err), 1);
    do_reset();

    // randomized legal traffic
    for (int c = 0; c < 800; c++) begin
      req = $urandom_range(0, 2);
      ret = $urandom_range(0, infl_q.size() < 2 ? infl_q.size() : 2);
      fv = $urandom_range(0, 3);
      tot = spec_q.size() + infl_q.size() - ret;
      allowed = 96 - tot;
      if ($countones(fv) > allowed) fv = (allowed == 1) ? 2 : 0;
      rec = ($urandom_range(0, 15) == 0);
      step(req, fv, $urandom_range(0, 127), $urandom_range(0, 127), ret, rec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
